// File: rtl/spectrum_bar_renderer_if.sv
// Frame-request / frame-buffer write bus of the spectrum bar renderer.
// The master side requests frames; the slave side (renderer) streams pixels.
interface spectrum_bar_renderer_if #(
  parameter int DS_WIDTH  = 32,
  parameter int DS_HEIGHT = 24,
  parameter int NUM_BARS  = 16,
  parameter int MAG_WIDTH = 8,
  parameter int PIX_WIDTH = 8
);
  localparam int ADDR_W = $clog2(DS_WIDTH * DS_HEIGHT);

  logic                          start;
  logic [NUM_BARS*MAG_WIDTH-1:0] mag_in;
  logic                          busy;
  logic                          frame_done;
  logic [ADDR_W-1:0]             write_addr;
  logic [PIX_WIDTH-1:0]          write_data;
  logic                          write_en;

  modport master (
    output start, mag_in,
    input  busy, frame_done, write_addr, write_data, write_en
  );

  modport slave (
    input  start, mag_in,
    output busy, frame_done, write_addr, write_data, write_en
  );
endinterface

// File: rtl/spectrum_bar_renderer.sv
// Renders one frame of spectrum bars with peak-hold markers into a frame buffer,
// one registered pixel write per cycle in raster order.
module spectrum_bar_renderer #(
  parameter int                   DS_WIDTH   = 32,
  parameter int                   DS_HEIGHT  = 24,
  parameter int                   NUM_BARS   = 16,
  parameter int                   MAG_WIDTH  = 8,
  parameter int                   PIX_WIDTH  = 8,
  parameter logic [PIX_WIDTH-1:0] BAR_COLOR  = 8'hE0,
  parameter logic [PIX_WIDTH-1:0] PEAK_COLOR = 8'hFF,
  parameter logic [PIX_WIDTH-1:0] BG_COLOR   = 8'h00,
  parameter int                   PEAK_HOLD  = 4
) (
  input logic                   clk,
  input logic                   rst,
  spectrum_bar_renderer_if.slave bus
);
  localparam int   BAR_W   = DS_WIDTH / NUM_BARS;
  localparam int   NPIX    = DS_WIDTH * DS_HEIGHT;
  localparam int   ADDR_W  = $clog2(NPIX);
  localparam int   H_W     = $clog2(DS_HEIGHT + 1);
  localparam int   PROD_W  = MAG_WIDTH + H_W;
  localparam int   X_W     = $clog2(DS_WIDTH + 1);
  localparam int   HOLD_W  = $clog2(PEAK_HOLD + 1);
  localparam logic HAS_GAP = (BAR_W > 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PEAK   = 3'd2,
    RENDER = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                        state_r, state_next_s;
  logic [NUM_BARS*MAG_WIDTH-1:0] mag_r;
  logic [H_W-1:0]                h_r        [NUM_BARS];
  logic [H_W-1:0]                peak_r     [NUM_BARS];
  logic [HOLD_W-1:0]             hold_r     [NUM_BARS];
  logic [PROD_W-1:0]             prod_s     [NUM_BARS];
  logic [H_W-1:0]                h_calc_s   [NUM_BARS];
  logic [H_W-1:0]                peak_upd_s [NUM_BARS];
  logic [HOLD_W-1:0]             hold_upd_s [NUM_BARS];
  logic [X_W-1:0]                x_r, bar_s, col_s;
  logic [H_W-1:0]                y_r, lvl_s, h_sel_s, peak_sel_s;
  int                            sel_s;
  logic [PIX_WIDTH-1:0]          pix_s, data_next_s, write_data_r;
  logic [ADDR_W-1:0]             addr_next_s, write_addr_r;
  logic                          emit_s, busy_next_s, done_next_s;
  logic                          busy_r, frame_done_r, write_en_r;

  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.write_addr = write_addr_r;
  assign bus.write_data = write_data_r;
  assign bus.write_en   = write_en_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic; the last RENDER cycle is the one presenting the final address
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = bus.start ? LOAD : IDLE;
      LOAD:    state_next_s = PEAK;
      PEAK:    state_next_s = RENDER;
      RENDER:  state_next_s = (write_addr_r == ADDR_W'(NPIX - 1)) ? DONE : RENDER;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Bar heights from the latched magnitudes
  always_comb begin
    for (int b = 0; b < NUM_BARS; b++) begin
      prod_s[b]   = PROD_W'(mag_r[b*MAG_WIDTH +: MAG_WIDTH]) * PROD_W'(DS_HEIGHT);
      h_calc_s[b] = H_W'(prod_s[b] >> MAG_WIDTH);
    end
  end

  // Peak-hold update; a decay only happens while peak > h, so it never underflows
  always_comb begin
    for (int b = 0; b < NUM_BARS; b++) begin
      peak_upd_s[b] = peak_r[b];
      hold_upd_s[b] = hold_r[b];
      if (h_r[b] >= peak_r[b]) begin
        peak_upd_s[b] = h_r[b];
        hold_upd_s[b] = HOLD_W'(0);
      end else if (hold_r[b] == HOLD_W'(PEAK_HOLD - 1)) begin
        peak_upd_s[b] = peak_r[b] - H_W'(1);
        hold_upd_s[b] = HOLD_W'(0);
      end else begin
        hold_upd_s[b] = hold_r[b] + HOLD_W'(1);
      end
    end
  end

  // Pixel colour; pixel 0 is produced during PEAK, so it sees the freshly updated peak
  always_comb begin
    bar_s      = x_r / X_W'(BAR_W);
    col_s      = x_r % X_W'(BAR_W);
    lvl_s      = H_W'(DS_HEIGHT - 1) - y_r;
    sel_s      = (bar_s < X_W'(NUM_BARS)) ? int'(bar_s) : 0;
    h_sel_s    = h_r[sel_s];
    peak_sel_s = (state_r == PEAK) ? peak_upd_s[sel_s] : peak_r[sel_s];
    if (x_r >= X_W'(NUM_BARS * BAR_W)) begin
      pix_s = BG_COLOR;
    end else if (HAS_GAP && (col_s == X_W'(BAR_W - 1))) begin
      pix_s = BG_COLOR;
    end else if (lvl_s < h_sel_s) begin
      pix_s = BAR_COLOR;
    end else if ((lvl_s == peak_sel_s) && (peak_sel_s != H_W'(0))) begin
      pix_s = PEAK_COLOR;
    end else begin
      pix_s = BG_COLOR;
    end
  end

  // Output decode: next values for the registered write port and status flags
  always_comb begin
    case (state_r)
      PEAK:    emit_s = 1'b1;
      RENDER:  emit_s = (write_addr_r != ADDR_W'(NPIX - 1));
      default: emit_s = 1'b0;
    endcase
    if (emit_s) begin
      addr_next_s = ADDR_W'(int'(y_r) * DS_WIDTH + int'(x_r));
      data_next_s = pix_s;
    end else begin
      addr_next_s = ADDR_W'(0);
      data_next_s = PIX_WIDTH'(0);
    end
    busy_next_s = (state_next_s != IDLE);
    done_next_s = (state_next_s == DONE);
  end

  // Frame datapath: latched magnitudes, heights, peak history and scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_r <= '0;
      x_r   <= X_W'(0);
      y_r   <= H_W'(0);
      for (int b = 0; b < NUM_BARS; b++) begin
        h_r[b]    <= H_W'(0);
        peak_r[b] <= H_W'(0);
        hold_r[b] <= HOLD_W'(0);
      end
    end else begin
      if ((state_r == IDLE) && bus.start) mag_r <= bus.mag_in;
      if (state_r == LOAD) h_r <= h_calc_s;
      if (state_r == PEAK) begin
        peak_r <= peak_upd_s;
        hold_r <= hold_upd_s;
      end
      if (emit_s) begin
        if (x_r == X_W'(DS_WIDTH - 1)) begin
          x_r <= X_W'(0);
          y_r <= (y_r == H_W'(DS_HEIGHT - 1)) ? H_W'(0) : y_r + H_W'(1);
        end else begin
          x_r <= x_r + X_W'(1);
        end
      end
    end
  end

  // Registered outputs; address, data and strobe move together
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      write_en_r   <= 1'b0;
      write_addr_r <= ADDR_W'(0);
      write_data_r <= PIX_WIDTH'(0);
    end else begin
      busy_r       <= busy_next_s;
      frame_done_r <= done_next_s;
      write_en_r   <= emit_s;
      write_addr_r <= addr_next_s;
      write_data_r <= data_next_s;
    end
  end
endmodule
